// File: rtl/even_parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : even_parity_pkg
//  Description : Shared types and default sizes for the even-parity receive
//                path: receiver FSM state encoding and default frame and
//                error-counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package even_parity_pkg;

    // Receiver FSM state encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

endpackage : even_parity_pkg
`default_nettype wire

// File: rtl/even_parity_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : even_parity_rx_if
//  Description : Bundle between a serial link front-end (master) and the
//                even-parity receiver (slave).
//                  sin, sin_valid, sof          : serial bit stream in
//                  dout, dout_valid, parity_err : completed word out
//                  frame_abort                  : partial frame discarded
//                  err_cnt                      : saturating failure count
//  Revision    : 1.0 - initial release
// ============================================================================
interface even_parity_rx_if
    import even_parity_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              sin;
    logic              sin_valid;
    logic              sof;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              parity_err;
    logic              frame_abort;
    logic [CNT_W-1:0]  err_cnt;

    // Front-end side: drives the bit stream, observes results.
    modport master (
        output sin, sin_valid, sof,
        input  dout, dout_valid, parity_err, frame_abort, err_cnt
    );

    // Receiver side.
    modport slave (
        input  sin, sin_valid, sof,
        output dout, dout_valid, parity_err, frame_abort, err_cnt
    );

endinterface : even_parity_rx_if
`default_nettype wire

// File: rtl/even_parity_rx_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Usable for any link-error tally.
//                  clk : rising-edge clock
//                  rst : asynchronous active-high reset, clears cnt
//                  inc : count one event this cycle
//                  cnt : current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/even_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : even_parity_rx
//  Description : Serial even-parity frame receiver. Collects DATA_W data bits
//                (LSB first, first bit flagged by sof) plus one parity bit,
//                presents the word with a parity-error flag and keeps a
//                saturating count of failed frames.
//                  clk : rising-edge clock
//                  rst : asynchronous active-high reset
//                  bus : even_parity_rx_if slave (stream in, word out)
//  Revision    : 1.0 - initial release
// ============================================================================
module even_parity_rx
    import even_parity_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    even_parity_rx_if.slave bus
);

    localparam int                BCNT_W        = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] c_BCNT_ONE    = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] c_BCNT_FULL   = BCNT_W'(DATA_W);
    // A one-bit word has nothing left to collect after sof.
    localparam state_t            c_AFTER_FIRST = (DATA_W == 1) ? PARITY : DATA;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_shift;
    logic [BCNT_W-1:0] r_cnt;
    logic              r_par;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_parity_err;
    logic              r_frame_abort;
    logic [CNT_W-1:0]  w_err_cnt;

    logic              w_start;
    logic              w_bit;
    logic [BCNT_W-1:0] w_cnt_inc;
    logic              w_shift;
    logic              w_complete;
    logic              w_abort;
    logic              w_err;

    // sof counts only with sin_valid; a sampled sof always restarts a frame.
    assign w_start   = bus.sin_valid & bus.sof;
    assign w_bit     = bus.sin_valid & ~bus.sof;
    assign w_cnt_inc = r_cnt + c_BCNT_ONE;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = c_AFTER_FIRST;
        end else if (w_bit) begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                DATA:    w_next_state = (w_cnt_inc == c_BCNT_FULL) ? PARITY : DATA;
                PARITY:  w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------- FSM controls
    always_comb begin
        w_shift    = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            DATA: begin
                w_shift = w_bit;
                w_abort = w_start;
            end
            PARITY: begin
                w_complete = w_bit;
                w_abort    = w_start;
            end
            default: begin
                w_shift    = 1'b0;
                w_complete = 1'b0;
                w_abort    = 1'b0;
            end
        endcase
    end

    assign w_err = r_par ^ bus.sin;

    // ------------------------------------------------------------ datapath
    // The shift register is zeroed when a frame starts, so later bits can be
    // OR-ed into place at the position given by the bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
        end else if (w_start) begin
            r_shift <= DATA_W'(bus.sin);
            r_cnt   <= c_BCNT_ONE;
            r_par   <= bus.sin;
        end else if (w_shift) begin
            r_shift <= r_shift | (DATA_W'(bus.sin) << r_cnt);
            r_cnt   <= w_cnt_inc;
            r_par   <= r_par ^ bus.sin;
        end
    end

    // ------------------------------------------------------------- outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_dout_valid  <= w_complete;
            r_frame_abort <= w_abort;
            if (w_complete) begin
                r_dout       <= r_shift;
                r_parity_err <= w_err;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_complete & w_err),
        .cnt (w_err_cnt)
    );

    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.parity_err  = r_parity_err;
    assign bus.frame_abort = r_frame_abort;
    assign bus.err_cnt     = w_err_cnt;

endmodule : even_parity_rx
`default_nettype wire

// File: tb/tb_even_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_even_parity_rx
//  Description : Scoreboard bench for even_parity_rx (DATA_W=8, CNT_W=2).
//                Directed frames push hand-computed results into queues; a
//                negedge monitor pops and compares whenever the receiver
//                reports a completed or aborted frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_even_parity_rx;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        logic [CNT_W-1:0]  c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   abort_pending = 0;
    exp_t mon_e;

    even_parity_rx_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    even_parity_rx #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dout_valid: actual dout=0x%0h required no completion", bus.dout);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout",       32'(bus.dout),       32'(mon_e.d));
                check("parity_err", 32'(bus.parity_err), 32'(mon_e.e));
                check("err_cnt",    32'(bus.err_cnt),    32'(mon_e.c));
            end
        end
        if (bus.frame_abort === 1'b1) begin
            checks++;
            if (abort_pending == 0) begin
                errors++;
                $display("FAIL unexpected_frame_abort: actual=1 required=0");
            end else begin
                abort_pending--;
            end
        end
    end

    // ------------------------------------------------------- stimulus aids
    task automatic drive(input logic v, input logic s, input logic b);
        bus.sin_valid = v;
        bus.sof       = s;
        bus.sin       = b;
        @(posedge clk);
        #1;
    endtask

    // Stall cycles carry a stray sof, which must be ignored without sin_valid.
    task automatic stall(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                              input int stall_mid, input int stall_par,
                              input logic [DATA_W-1:0] ed, input logic ee,
                              input logic [CNT_W-1:0] ec);
        exp_t x;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == 4) stall(stall_mid);
            drive(1'b1, (i == 0), data[i]);
        end
        stall(stall_par);
        x.d = ed; x.e = ee; x.c = ec;
        exp_q.push_back(x);
        drive(1'b1, 1'b0, par);
        bus.sin_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dout"},        32'(bus.dout),        32'h0);
        check({tag, "_dout_valid"},  32'(bus.dout_valid),  32'h0);
        check({tag, "_parity_err"},  32'(bus.parity_err),  32'h0);
        check({tag, "_frame_abort"}, 32'(bus.frame_abort), 32'h0);
        check({tag, "_err_cnt"},     32'(bus.err_cnt),     32'h0);
    endtask

    // -------------------------------------------------------------- main
    initial begin
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.sof       = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // Good frame, then bad parity, then good frame with parity 1.
        send_frame(8'hA5, 1'b0, 0, 0, 8'hA5, 1'b0, 2'd0);
        send_frame(8'hA5, 1'b1, 0, 0, 8'hA5, 1'b1, 2'd1);
        send_frame(8'h01, 1'b1, 0, 0, 8'h01, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b0);

        // Stalls between bits 3/4 and between bit 7 and parity.
        send_frame(8'h3C, 1'b0, 5, 5, 8'h3C, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b0);

        // Abort: four bits of a frame, then a new sof starts 0xFF.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        abort_pending++;
        send_frame(8'hFF, 1'b0, 0, 0, 8'hFF, 1'b0, 2'd1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Clean reset so saturation starts from zero.
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        check("reset2_err_cnt", 32'(bus.err_cnt), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // Saturation: back-to-back frames, 0x80 has odd weight so parity 0 fails.
        send_frame(8'h80, 1'b0, 0, 0, 8'h80, 1'b1, 2'd1);
        send_frame(8'h80, 1'b0, 0, 0, 8'h80, 1'b1, 2'd2);
        send_frame(8'h80, 1'b0, 0, 0, 8'h80, 1'b1, 2'd3);
        send_frame(8'h80, 1'b0, 0, 0, 8'h80, 1'b1, 2'd3);
        send_frame(8'h80, 1'b0, 0, 0, 8'h80, 1'b1, 2'd3);
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Reset mid-frame: five bits in, assert rst between clock edges.
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
        bus.sin_valid = 1'b0;
        bus.sof       = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        // A bit without sof straight after release must be dropped in IDLE.
        drive(1'b1, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 0, 0, 8'h0F, 1'b0, 2'd0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);

        check("pending_frames", 32'(exp_q.size()), 32'h0);
        check("pending_aborts", 32'(abort_pending), 32'h0);
        check("dout_held",      32'(bus.dout),      32'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_even_parity_rx
`default_nettype wire

// File: doc/even_parity_rx.md
# even_parity_rx

Serial even-parity frame receiver and checker, the receive end of the even-parity protocol. A frame is a start-of-frame-qualified run of DATA_W data bits, LSB first, followed by one parity bit. The block reassembles the word, checks that data bits XOR parity bit equals 0, and presents the word with an error flag. It also keeps a saturating count of parity failures. It sits between a serial link front-end and the word-level consumer.

## Interface
- DATA_W, 8, number of data bits per frame (≥1)
- CNT_W, 8, width of the parity-error counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- sin  in  1  serial data/parity bit
- sin_valid  in  1  sin is sampled on clk when high; low = stall
- sof  in  1  start of frame; meaningful only with sin_valid, marks sin as data bit 0
- dout  out  DATA_W  last received word; held until the next completed frame
- dout_valid  out  1  one-cycle pulse when a frame completes
- parity_err  out  1  high when the last completed frame failed the check; held with dout
- frame_abort  out  1  one-cycle pulse when a frame is cut short by a new sof
- err_cnt  out  CNT_W  saturating count of failed frames

## Operation
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - sin_valid&&sof → shift reg bit 0 = sin, running parity = sin, bit count = 1.
  - Next state is DATA, or PARITY if DATA_W==1.
  - sin_valid without sof is discarded.
- DATA:
  - sin_valid&&!sof → store sin at index bit count, XOR it into running parity, increment count.
  - When count reaches DATA_W → PARITY.
- PARITY:
  - sin_valid&&!sof → error = running parity ^ sin.
  - Load dout, set parity_err = error, pulse dout_valid.
  - If error and err_cnt < 2^CNT_W−1, increment err_cnt.
  - Next state is IDLE.
- sof with sin_valid in DATA or PARITY:
  - Pulse frame_abort and discard the partial frame; dout, parity_err and err_cnt are unchanged.
  - Restart with sin as bit 0, as from IDLE, in the same cycle. No bits are lost.
- sof without sin_valid is ignored in every state.
- sin_valid low: all state holds; this is legal anywhere, including between the last data bit and the parity bit.
- The counter saturates at all-ones and never wraps. An aborted frame never counts as an error.

## Timing
- All outputs are registered.
- dout, dout_valid and parity_err update on the clk edge that samples the parity bit, so they are visible the following cycle (latency 1 from parity-bit sample).
- err_cnt updates on the same edge as dout_valid.
- frame_abort is visible the cycle after the aborting sof is sampled.
- Back-to-back frames are allowed: a sof bit may arrive in the cycle right after the parity bit. Throughput is one bit per clk.
- Reset (asynchronous assert, any time including mid-frame):
  - State IDLE; dout=0, dout_valid=0, parity_err=0, frame_abort=0, err_cnt=0; shift reg, count and running parity cleared.
  - The partial frame is discarded.
  - The first sampled edge after release behaves as IDLE.

## Structure
- Package even_parity_pkg: state enum (IDLE, DATA, PARITY) and default DATA_W/CNT_W constants.
- Sub-module sat_counter (parameter CNT_W; inputs clk, rst, inc; output cnt) for err_cnt. It is reusable by other link-error counters.
- Bit count width is $clog2(DATA_W+1).

## Test plan
Parameters for all scenarios: DATA_W=8, CNT_W=2.
- Good frame: sof + bits of 0xA5, LSB first, then parity 0 → one cycle later dout=0xA5, dout_valid pulse, parity_err=0, err_cnt=0.
- Bad parity: 0xA5 with parity 1 → dout=0xA5, parity_err=1, err_cnt=1; next good frame 0x01 with parity 1 → parity_err=0, err_cnt stays 1.
- Stall: 0x3C with sin_valid low for 5 cycles between bits 3/4 and between bit 7/parity → dout=0x3C, exactly one dout_valid pulse.
- Abort: 4 bits, then sof mid-frame, then full 0xFF with parity 0 → frame_abort pulse, then dout=0xFF, err_cnt unchanged.
- Saturation: 5 consecutive bad-parity frames → err_cnt=1,2,3,3,3.
- Reset mid-frame: rst asserted after bit 5 → all outputs 0 immediately. After release, sof + 0x0F with parity 0 → dout=0x0F, parity_err=0.
